// File: rtl/alu_seq_core.sv
// alu_seq_core: parametrised sequential ALU with start/done handshake.
// Single-cycle ADD/SUB/AND/OR/XOR/SHL plus iterative unsigned MUL/DIV.
// Ports: clk, rst_n (async, active low), ena (clock enable), start, op[2:0],
//        a/b[WIDTH-1:0] in; busy, done, res_lo/res_hi[WIDTH-1:0],
//        flags[3:0] = {Z, C, V, DZ} out.
module alu_seq_core #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [3:0]       flags
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // lo_q holds operand a on accept; during MUL it is the shifting
    // multiplier / product low half, during DIV the quotient.
    // hi_q is the product high half (MUL) or partial remainder (DIV).
    logic [2:0]       op_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [CW-1:0]    count;

    logic iter_req;
    assign iter_req = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

    // Shift-add multiply step.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring divide step. The partial remainder is always below the
    // divisor, so the difference fits in WIDTH bits when it is kept.
    logic [WIDTH:0]   div_shl;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    assign div_shl = {hi_q, lo_q[WIDTH-1]};
    assign div_ge  = div_shl >= {1'b0, b_q};
    assign div_sub = div_shl[WIDTH-1:0] - b_q;
    assign div_hi  = div_ge ? div_sub : div_shl[WIDTH-1:0];
    assign div_lo  = {lo_q[WIDTH-2:0], div_ge};

    // Single-cycle datapath on the latched operands.
    logic [WIDTH:0] add_w;
    logic [WIDTH:0] sub_w;
    logic [WIDTH:0] shl_w;
    assign add_w = {1'b0, lo_q} + {1'b0, b_q};
    assign sub_w = {1'b0, lo_q} - {1'b0, b_q};
    // Bit WIDTH of the widened shift is the last bit shifted out.
    assign shl_w = {1'b0, lo_q} << b_q[CW-1:0];

    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_c;
    logic             r_v;
    logic             r_dz;
    logic             r_z;

    always_comb begin
        r_lo = '0;
        r_hi = '0;
        r_c  = 1'b0;
        r_v  = 1'b0;
        r_dz = 1'b0;
        case (op_q)
            OP_ADD: begin
                r_lo = add_w[WIDTH-1:0];
                r_c  = add_w[WIDTH];
                r_v  = (lo_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (add_w[WIDTH-1] != lo_q[WIDTH-1]);
            end
            OP_SUB: begin
                r_lo = sub_w[WIDTH-1:0];
                r_c  = sub_w[WIDTH];
                r_v  = (lo_q[WIDTH-1] != b_q[WIDTH-1]) &&
                       (sub_w[WIDTH-1] != lo_q[WIDTH-1]);
            end
            OP_AND: r_lo = lo_q & b_q;
            OP_OR:  r_lo = lo_q | b_q;
            OP_XOR: r_lo = lo_q ^ b_q;
            OP_SHL: begin
                r_lo = shl_w[WIDTH-1:0];
                r_c  = shl_w[WIDTH];
            end
            OP_MUL: begin
                r_lo = lo_q;
                r_hi = hi_q;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    r_lo = '1;
                    r_hi = lo_q;
                    r_dz = 1'b1;
                end else begin
                    r_lo = lo_q;
                    r_hi = hi_q;
                end
            end
            default: ;
        endcase
    end

    assign r_z = (r_lo == '0) && (r_hi == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ena) begin
            case (state)
                IDLE: if (start) state_nxt = iter_req ? EXEC : DONE;
                EXEC: if (count == CW'(1)) state_nxt = DONE;
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            b_q    <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            res_lo <= '0;
            res_hi <= '0;
            flags  <= '0;
        end else if (ena) begin
            done <= 1'b0;
            // Registered one cycle behind the state so busy rises the
            // cycle after accept and drops together with done.
            busy <= (state == EXEC);
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        b_q   <= b;
                        lo_q  <= a;
                        hi_q  <= '0;
                        count <= iter_req ? CW'(WIDTH) : '0;
                    end
                end
                EXEC: begin
                    count <= count - CW'(1);
                    if (op_q == OP_MUL) begin
                        hi_q <= mul_hi;
                        lo_q <= mul_lo;
                    end else begin
                        hi_q <= div_hi;
                        lo_q <= div_lo;
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    res_lo <= r_lo;
                    res_hi <= r_hi;
                    flags  <= {r_z, r_c, r_v, r_dz};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed bench for alu_seq_core at WIDTH=8 and WIDTH=16.
// A behavioural reference model is compared to the 8-bit DUT every cycle.
module tb_alu_seq_core;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] res_lo;
    logic [7:0] res_hi;
    logic [3:0] flags;

    logic        start16;
    logic [2:0]  op16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        busy16;
    logic        done16;
    logic [15:0] lo16;
    logic [15:0] hi16;
    logic [3:0]  flags16;

    int npass = 0;
    int ntot  = 0;

    alu_seq_core #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .res_lo(res_lo), .res_hi(res_hi), .flags(flags)
    );

    alu_seq_core #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start16), .op(op16),
        .a(a16), .b(b16), .busy(busy16), .done(done16),
        .res_lo(lo16), .res_hi(hi16), .flags(flags16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [67:0] act,
                       input logic [67:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: returns {hi[31:0], lo[31:0], Z, C, V, DZ} for width w.
    function automatic logic [67:0] model(input int w, input logic [2:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] mask, lo, hi, full;
        logic c, v, dz, z;
        int amt, cw;
        mask = (64'd1 << w) - 64'd1;
        lo = 0; hi = 0; c = 0; v = 0; dz = 0;
        cw = $clog2(w + 1);
        case (o)
            3'd0: begin
                full = x + y;
                lo = full & mask;
                c = full[w];
                v = (x[w-1] == y[w-1]) && (lo[w-1] != x[w-1]);
            end
            3'd1: begin
                full = x - y;
                lo = full & mask;
                c = x < y;
                v = (x[w-1] != y[w-1]) && (lo[w-1] != x[w-1]);
            end
            3'd2: lo = x & y;
            3'd3: lo = x | y;
            3'd4: lo = x ^ y;
            3'd5: begin
                amt = int'(y & ((32'd1 << cw) - 1));
                lo = (amt >= w) ? 64'd0 : ((x << amt) & mask);
                c = (amt >= 1 && amt <= w) ? x[w-amt] : 1'b0;
            end
            3'd6: begin
                full = x * y;
                lo = full & mask;
                hi = full >> w;
            end
            default: begin
                if (y == 0) begin
                    lo = mask; hi = x; dz = 1;
                end else begin
                    lo = x / y; hi = x % y;
                end
            end
        endcase
        z = (lo == 0) && (hi == 0);
        return {hi[31:0], lo[31:0], z, c, v, dz};
    endfunction

    // Transaction-level model of the 8-bit DUT: an accepted op completes
    // after 1 or WIDTH+1 enabled cycles; results appear with done.
    logic        m_pend;
    logic        m_multi;
    int          m_rem;
    logic [2:0]  m_op;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [67:0] m_res;
    logic        e_done;
    logic        e_busy;

    assign e_busy = m_pend && m_multi && (m_rem <= 8);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  <= 0;
            m_multi <= 0;
            m_rem   <= 0;
            m_op    <= 0;
            m_a     <= 0;
            m_b     <= 0;
            m_res   <= 0;
            e_done  <= 0;
        end else if (ena) begin
            e_done <= 0;
            if (m_pend) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_pend <= 0;
                    e_done <= 1;
                    m_res  <= model(8, m_op, 32'(m_a), 32'(m_b));
                end
            end else if (start) begin
                m_pend  <= 1;
                m_op    <= op;
                m_a     <= a;
                m_b     <= b;
                m_multi <= (op == 3'd6) || (op == 3'd7 && b != 0);
                m_rem   <= ((op == 3'd6) || (op == 3'd7 && b != 0)) ? 9 : 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cycle", {done, busy, flags, res_hi, res_lo},
                {e_done, e_busy, m_res[3:0], m_res[43:36], m_res[11:4]});
        end
    end

    // mode 1: pulse start while busy; mode 2: drop ena for 3 cycles.
    task automatic run8(input string nm, input logic [2:0] o,
                        input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] elo, input logic [7:0] ehi,
                        input logic [3:0] ef, input int elat,
                        input int mode);
        int lat;
        @(negedge clk);
        op = o; a = x; b = y; start = 1;
        @(negedge clk);
        start = 0; a = 8'hA5; b = 8'h5A;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (mode == 1 && lat == 3) begin op = 3'd0; start = 1; end
            if (mode == 1 && lat == 4) start = 0;
            if (mode == 2 && lat == 4) ena = 0;
            if (mode == 2 && lat == 7) ena = 1;
            if (done) break;
        end
        chk({nm, "_lat"}, 68'(lat), 68'(elat));
        chk({nm, "_lo"}, 68'(res_lo), 68'(elo));
        chk({nm, "_hi"}, 68'(res_hi), 68'(ehi));
        chk({nm, "_flags"}, 68'(flags), 68'(ef));
    endtask

    initial begin
        int ndone;
        int lat;
        logic [67:0] exp;
        logic [2:0]  o;
        logic [15:0] x;
        logic [15:0] y;

        rst_n = 0; ena = 1; start = 0; op = 0; a = 0; b = 0;
        start16 = 0; op16 = 0; a16 = 0; b16 = 0;
        repeat (2) @(negedge clk);
        chk("reset_state", {done, busy, flags, res_hi, res_lo}, 68'd0);
        rst_n = 1;

        chk("model_shl", model(8, 3'd5, 32'h81, 32'd1),
            {32'h0, 32'h02, 4'b0100});
        chk("model_mul16", model(16, 3'd6, 32'hFFFF, 32'hFFFF),
            {32'hFFFE, 32'h0001, 4'b0000});

        run8("add_c",   3'd0, 8'd200, 8'd100, 8'h2C, 8'h00, 4'b0100, 1, 0);
        run8("add_v",   3'd0, 8'd100, 8'd100, 8'hC8, 8'h00, 4'b0010, 1, 0);
        run8("sub_b",   3'd1, 8'd5,   8'd7,   8'hFE, 8'h00, 4'b0100, 1, 0);
        run8("sub_v",   3'd1, 8'h80,  8'h01,  8'h7F, 8'h00, 4'b0010, 1, 0);
        run8("shl1",    3'd5, 8'h81,  8'd1,   8'h02, 8'h00, 4'b0100, 1, 0);
        run8("shl8",    3'd5, 8'h81,  8'd8,   8'h00, 8'h00, 4'b1100, 1, 0);
        run8("shl9",    3'd5, 8'h81,  8'd9,   8'h00, 8'h00, 4'b1000, 1, 0);
        run8("and",     3'd2, 8'hF0,  8'h0F,  8'h00, 8'h00, 4'b1000, 1, 0);
        run8("or",      3'd3, 8'hF0,  8'h0F,  8'hFF, 8'h00, 4'b0000, 1, 0);
        run8("xor",     3'd4, 8'hFF,  8'h0F,  8'hF0, 8'h00, 4'b0000, 1, 0);
        run8("mul",     3'd6, 8'd200, 8'd3,   8'h58, 8'h02, 4'b0000, 9, 1);
        run8("div",     3'd7, 8'd200, 8'd7,   8'h1C, 8'h04, 4'b0000, 9, 0);
        run8("div0",    3'd7, 8'h55,  8'h00,  8'hFF, 8'h55, 4'b0001, 1, 0);
        run8("mul_stl", 3'd6, 8'd200, 8'd3,   8'h58, 8'h02, 4'b0000, 12, 2);

        @(negedge clk);
        op = 3'd6; a = 8'd200; b = 8'd3; start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 68'(busy), 68'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_busy", 68'(busy), 68'd0);
        chk("rst_done", 68'(done), 68'd0);
        chk("rst_res", {res_hi, res_lo}, 68'd0);
        chk("rst_flags", 68'(flags), 68'd0);
        @(negedge clk);
        rst_n = 1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_no_done", 68'(ndone), 68'd0);

        run8("mul_post", 3'd6, 8'd15, 8'd17, 8'hFF, 8'h00, 4'b0000, 9, 0);

        for (int i = 0; i < 20; i++) begin
            o = (i % 2 == 1) ? 3'd7 : 3'd6;
            x = 16'($urandom);
            y = 16'($urandom);
            if (i == 0) begin x = 16'hFFFF; y = 16'hFFFF; end
            if (i == 1) begin x = 16'd1234; y = 16'd0; end
            if (i == 2) begin x = 16'd0; y = 16'd77; end
            if (i == 3) begin x = 16'd9; y = 16'd40000; end
            if (i == 5) begin x = 16'hFFFF; y = 16'd1; end
            exp = model(16, o, 32'(x), 32'(y));
            @(negedge clk);
            op16 = o; a16 = x; b16 = y; start16 = 1;
            @(negedge clk);
            start16 = 0;
            lat = 0;
            while (lat < 40) begin
                @(negedge clk);
                lat++;
                if (done16) break;
            end
            chk("w16_lat", 68'(lat), (o == 3'd7 && y == 0) ? 68'd1 : 68'd17);
            chk("w16_res", {flags16, hi16, lo16},
                {exp[3:0], exp[51:36], exp[19:4]});
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
